seq_run_logger: RTL and testbench
=================================

// Module: seq_run_logger
// PURPOSE
//  Downstream consumer of the serial "111" sequence detector. Samples the detector's
//  1-bit match output on each valid bit slot. Groups consecutive matches into runs and
//  logs one record {run length, start timestamp} per finished run. Records go into a
//  small FIFO drained by a valid/ready interface. Also keeps a saturating total match count.
// PARAMETERS
//  LEN_W   8  width of run-length field; run length saturates at 2**LEN_W-1
//  TS_W    16 width of bit-slot timestamp; wraps modulo 2**TS_W
//  CNT_W   16 width of total match counter; saturates at all-ones
//  DEPTH   4  record FIFO depth; power of two, >=2
// PORTS
//  clk      in  1      clock, rising edge
//  rst      in  1      reset, asynchronous, active-low
//  clr      in  1      synchronous clear; same effect as reset, takes priority over all inputs
//  bit_vld  in  1      high when det_in is a valid sample for the current bit slot
//  det_in   in  1      detector match output; ignored when bit_vld=0
//  rec_vld  out 1      FIFO non-empty; head record presented
//  rec_rdy  in  1      consumer accepts head when rec_vld&rec_rdy
//  rec_len  out LEN_W  head record run length (matches in run)
//  rec_ts   out TS_W   head record timestamp of first match in run
//  total    out CNT_W  total matched bit slots since reset/clr
//  busy     out 1      FSM in RUN (run open, not yet logged)
//  ovf      out 1      sticky: a record was dropped on full FIFO
// BEHAVIOUR
//  Reset/clr: all outputs 0. FSM=IDLE, ts=0, run_len=0, FIFO empty, ovf=0.
//  Reset asserted mid-run discards the open run and all queued records.
//  Timestamp ts: increments by 1 on every bit_vld cycle; wraps at 2**TS_W-1 -> 0.
//  The record captures the ts value of the slot holding the run's first match, before that slot's increment.
//  bit_vld=0 cycles: FSM, run_len and ts hold; FIFO pops still proceed.
//  FSM IDLE: bit_vld&det_in -> RUN, run_len<=1, start_ts<=ts, busy=1 next cycle.
//  FSM RUN: bit_vld&det_in -> stay, run_len<=run_len+1 (saturate at all-ones).
//           bit_vld&!det_in -> push {run_len,start_ts}, -> IDLE.
//  total: +1 on every bit_vld&det_in cycle; saturates, never wraps.
//  Record latency: rec_vld is high the cycle after the terminating 0 is sampled, if the FIFO was empty.
//  FIFO: show-ahead. rec_len/rec_ts are valid whenever rec_vld=1 and hold stable until popped.
//  Pop when rec_vld&rec_rdy. rec_len/rec_ts are don't-care when rec_vld=0; drive 0.
//  Push when full with no pop: record dropped, ovf<=1 (sticky until rst/clr).
//  Push and pop in the same cycle when full: both occur, no drop, ovf unchanged.
//  Push and pop in the same cycle when empty: push only (pop not valid).
//  Pointers wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
//  A run still open (busy=1) is never logged until a 0 slot arrives.
// STRUCTURE
//  Shared package seq_pkg:
//   - FSM state type {IDLE, RUN}
//   - LEN_W/TS_W defaults
//   - record struct {len, ts}
//  One sub-module: seq_rec_fifo (sync FIFO, DEPTH x (LEN_W+TS_W)).
//   - Ports: push, pop, full, empty, head data.
//  Top holds FSM, ts counter, run_len/start_ts registers, total counter, ovf.
// TESTING
//  1. Reset values: rst=0 then release -> all outputs 0 for 3 idle cycles.
//  2. Single run: det_in 0,1,1,1,0 (bit_vld=1) -> one record len=3, ts=1.
//     rec_vld rises the cycle after the final 0. total=3.
//  3. Backpressure and overflow (DEPTH=4, rec_rdy=0): five runs 1,0 -> four records held.
//     ovf=1 after the fifth terminating 0. Then drain with rec_rdy=1 -> len=1 ts=0,2,4,6.
//  4. Full push+pop: FIFO full, rec_rdy=1 in the same cycle a run ends -> no drop, ovf stays 0.
//     The new record is last in order.
//  5. Gaps and saturation (LEN_W=2): det_in=1 for 6 slots with bit_vld toggling -> run_len stays 3.
//     ts advances only on valid slots. Record len=3.
//  6. Mid-run clear: start a run, clr=1 for 1 cycle -> busy=0, FIFO empty, ts=0, total=0, no record.
//     Repeat with async rst low mid-cycle -> same result.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// seq_pkg : shared types for the "111" run logger (FSM states, record layout)
// Rev 1.0
// ============================================================================
package seq_pkg;

    localparam int LEN_W_DEF = 8;
    localparam int TS_W_DEF  = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Record layout at the default field widths; len sits above ts when packed.
    typedef struct packed {
        logic [LEN_W_DEF-1:0] len;
        logic [TS_W_DEF-1:0]  ts;
    } rec_t;

endpackage
`default_nettype wire

// File: rtl/seq_rec_fifo.sv
`default_nettype none
// ============================================================================
// seq_rec_fifo : show-ahead synchronous record FIFO, DEPTH x W
// Rev 1.0
// ============================================================================
module seq_rec_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_pop_ok;
    logic          w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign w_pop_ok  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_push_ok = push & (~full | w_pop_ok);
    assign dout      = empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + AW'(1);
            if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/seq_run_logger.sv
`default_nettype none
// ============================================================================
// seq_run_logger : groups consecutive detector matches into runs and queues
//                  one {length, start timestamp} record per finished run
// Rev 1.0
// ============================================================================
module seq_run_logger
    import seq_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_vld,
    input  logic             det_in,
    output logic             rec_vld,
    input  logic             rec_rdy,
    output logic [LEN_W-1:0] rec_len,
    output logic [TS_W-1:0]  rec_ts,
    output logic [CNT_W-1:0] total,
    output logic             busy,
    output logic             ovf
);

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [TS_W-1:0]  ts;
    } rec_w_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_start_ts;
    logic [LEN_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_total;
    logic             r_ovf;
    logic             w_hit;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    rec_w_t           w_din;
    rec_w_t           w_dout;

    assign w_hit = bit_vld & det_in;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: if (w_hit) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (bit_vld && !det_in) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ts       <= '0;
            r_start_ts <= '0;
            r_run_len  <= '0;
            r_total    <= '0;
            r_ovf      <= 1'b0;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_ts       <= '0;
            r_start_ts <= '0;
            r_run_len  <= '0;
            r_total    <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (bit_vld) r_ts <= r_ts + TS_W'(1);
            if (w_hit) begin
                if (r_state == ST_IDLE) begin
                    r_run_len  <= LEN_W'(1);
                    r_start_ts <= r_ts;
                end else if (r_run_len != '1) begin
                    r_run_len  <= r_run_len + LEN_W'(1);
                end
                if (r_total != '1) r_total <= r_total + CNT_W'(1);
            end
            // A full FIFO only drops when the consumer is not popping this cycle.
            if (w_push && w_full && !rec_rdy) r_ovf <= 1'b1;
        end
    end

    assign w_din.len = r_run_len;
    assign w_din.ts  = r_start_ts;

    seq_rec_fifo #(
        .W     (LEN_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (w_push),
        .pop   (rec_rdy),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .dout  (w_dout)
    );

    assign rec_vld = ~w_empty;
    assign rec_len = w_dout.len;
    assign rec_ts  = w_dout.ts;
    assign total   = r_total;
    assign busy    = (r_state == ST_RUN);
    assign ovf     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_run_logger.sv
`default_nettype none
// ============================================================================
// tb_seq_run_logger : directed self-checking bench for seq_run_logger
// Rev 1.0
// ============================================================================
module tb_seq_run_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        bit_vld = 1'b0;
    logic        det_in = 1'b0;
    logic        rec_rdy = 1'b0;

    logic        rec_vld, busy, ovf;
    logic [7:0]  rec_len;
    logic [15:0] rec_ts, total;

    logic        rec_vld2, busy2, ovf2;
    logic [1:0]  rec_len2;
    logic [15:0] rec_ts2, total2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_run_logger dut (
        .clk(clk), .rst(rst), .clr(clr), .bit_vld(bit_vld), .det_in(det_in),
        .rec_vld(rec_vld), .rec_rdy(rec_rdy), .rec_len(rec_len), .rec_ts(rec_ts),
        .total(total), .busy(busy), .ovf(ovf)
    );

    seq_run_logger #(.LEN_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .bit_vld(bit_vld), .det_in(det_in),
        .rec_vld(rec_vld2), .rec_rdy(rec_rdy), .rec_len(rec_len2), .rec_ts(rec_ts2),
        .total(total2), .busy(busy2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle at the falling edge, return just after the rising edge.
    task automatic step(input logic v, input logic d, input logic r);
        @(negedge clk);
        bit_vld = v;
        det_in  = d;
        rec_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1; bit_vld = 1'b0; det_in = 1'b0; rec_rdy = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_vld"},   {31'd0, rec_vld}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},    32'd0);
        chk({tag, "_ovf"},   {31'd0, ovf},     32'd0);
        chk({tag, "_total"}, {16'd0, total},   32'd0);
        chk({tag, "_len"},   {24'd0, rec_len}, 32'd0);
        chk({tag, "_ts"},    {16'd0, rec_ts},  32'd0);
    endtask

    initial begin
        // 1. reset values
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk_cleared("rst");
        end

        // 2. single run 0,1,1,1,0 -> len 3 ts 1
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t2_vld_open", {31'd0, rec_vld}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("t2_vld",   {31'd0, rec_vld}, 32'd1);
        chk("t2_len",   {24'd0, rec_len}, 32'd3);
        chk("t2_ts",    {16'd0, rec_ts},  32'd1);
        chk("t2_total", {16'd0, total},   32'd3);
        chk("t2_idle",  {31'd0, busy},    32'd0);
        step(1'b0, 1'b0, 1'b0);
        chk("t2_hold_len", {24'd0, rec_len}, 32'd3);
        step(1'b0, 1'b0, 1'b1);
        chk("t2_popped", {31'd0, rec_vld}, 32'd0);
        chk("t2_len0",   {24'd0, rec_len}, 32'd0);

        // 3. backpressure and overflow
        do_clr();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
            if (k == 3) chk("t3_ovf_full", {31'd0, ovf}, 32'd0);
        end
        chk("t3_ovf", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_vld", {31'd0, rec_vld}, 32'd1);
            chk("t3_len", {24'd0, rec_len}, 32'd1);
            chk("t3_ts",  {16'd0, rec_ts},  32'(2 * i));
            step(1'b0, 1'b0, 1'b1);
        end
        chk("t3_empty",      {31'd0, rec_vld}, 32'd0);
        chk("t3_ovf_sticky", {31'd0, ovf},     32'd1);

        // 4. push and pop together while full
        do_clr();
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("t4_ovf", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_vld", {31'd0, rec_vld}, 32'd1);
            chk("t4_ts",  {16'd0, rec_ts},  32'(2 * i + 2));
            step(1'b0, 1'b0, 1'b1);
        end
        chk("t4_empty", {31'd0, rec_vld}, 32'd0);

        // 5. gaps and saturation on the LEN_W=2 instance
        do_clr();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_ignored", {31'd0, busy2}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i < 5) step(1'b0, 1'b1, 1'b0);
        end
        chk("t5_busy",  {31'd0, busy2},   32'd1);
        chk("t5_total", {16'd0, total2},  32'd6);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_len",      {30'd0, rec_len2}, 32'd3);
        chk("t5_ts",       {16'd0, rec_ts2},  32'd1);
        chk("t5_len_wide", {24'd0, rec_len},  32'd6);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_len2", {30'd0, rec_len2}, 32'd1);
        chk("t5_ts2",  {16'd0, rec_ts2},  32'd8);

        // 6. mid-run synchronous clear
        do_clr();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        do_clr();
        chk_cleared("t6_clr");
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_clr_ts",  {16'd0, rec_ts},  32'd0);
        chk("t6_clr_len", {24'd0, rec_len}, 32'd1);

        // 6b. asynchronous reset in the middle of a cycle
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        #2 rst = 1'b0;
        #1;
        chk_cleared("t6_rst");
        @(negedge clk);
        bit_vld = 1'b0; det_in = 1'b0;
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("t6_rst_ts",    {16'd0, rec_ts},  32'd0);
        chk("t6_rst_total", {16'd0, total},   32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
